// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_sync.sv
// Generic two-flop synchronizer with a configurable reset value.
module uart_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver: mid-bit sampling, framing-error detection and break recovery.
// Defining UART_RX_PARITY_EN switches framing to 8E1 and adds the parity_err output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int NUM_CLKS_PER_BIT = 16
) (
  input  logic       rx_clk,
  input  logic       rx_rstn,
  input  logic       rx,
  output logic [7:0] rx_dout,
  output logic       rx_done,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int CW = $clog2(NUM_CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_HALF = cnt_t'(NUM_CLKS_PER_BIT / 2 - 1);
  localparam cnt_t CNT_LAST = cnt_t'(NUM_CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

  if (NUM_CLKS_PER_BIT < 4 || (NUM_CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
    $error("uart_receiver: NUM_CLKS_PER_BIT must be even and >= 4");
  end

  rx_state_t  state, state_next;
  cnt_t       clk_cnt, cnt_next;
  logic [2:0] bit_idx, idx_next;
  uart_byte_t shift_reg, shift_next;
  uart_byte_t dout_next;
  logic       done_next, ferr_next;
  logic       rx_s;
`ifdef UART_RX_PARITY_EN
  logic       parity_bit, parity_bit_next, perr_next;
`endif

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (rx_clk),
    .rstn (rx_rstn),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rx_dout    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      clk_cnt    <= cnt_next;
      bit_idx    <= idx_next;
      shift_reg  <= shift_next;
      rx_dout    <= dout_next;
      rx_done    <= done_next;
      frame_err  <= ferr_next;
`ifdef UART_RX_PARITY_EN
      parity_bit <= parity_bit_next;
      parity_err <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt + cnt_t'(1);
    idx_next   = bit_idx;
    shift_next = shift_reg;
    dout_next  = rx_dout;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit;
    perr_next       = 1'b0;
`endif

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // A line that is high again at mid-start-bit was a glitch
        if (clk_cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          idx_next   = bit_idx + 3'd1;
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          parity_bit_next = rx_s;
          state_next      = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          if (rx_s) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_reg, parity_bit}) begin
              perr_next = 1'b1;
            end else begin
              dout_next = shift_reg;
              done_next = 1'b1;
            end
`else
            dout_next = shift_reg;
            done_next = 1'b1;
`endif
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) begin
      cnt_next = '0;
      idx_next = '0;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written corner sequences,
// with a scoreboard of expected output pulses. Honours UART_RX_PARITY_EN.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * N;
  // Start edge on rx to rx_done, nominal, with the allowed jitter window
  localparam int LAT_NOM = N / 2 + (FRAME_BITS - 1) * N + 1;
  localparam int LAT_TOL = 3;
  localparam int NUM_VECS = 5;

  typedef enum logic [1:0] {EV_NONE, EV_DONE, EV_FERR, EV_PERR} ev_t;

  typedef struct {
    ev_t        kind;
    uart_byte_t dout;
    int         startCycle;
  } sb_t;

  typedef struct {
    uart_byte_t data;
    logic       stopBit;
    logic       flipParity;
    int         gapBits;
    ev_t        expKind;
    uart_byte_t expDout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       rx;
  logic [7:0] rxDout;
  logic       rxDone;
  logic       frameErr;
  logic       parityErr;
  logic       rxBusy;

  int assertions = 0;
  int failures   = 0;
  int cycle      = 0;
  sb_t sb[$];
  int doneCycles[$];
  vec_t vecs[NUM_VECS];

  uart_receiver #(.NUM_CLKS_PER_BIT(N)) dut (
    .rx_clk     (clk),
    .rx_rstn    (rstN),
    .rx         (rx),
    .rx_dout    (rxDout),
    .rx_done    (rxDone),
    .frame_err  (frameErr),
`ifdef UART_RX_PARITY_EN
    .parity_err (parityErr),
`endif
    .rx_busy    (rxBusy)
  );

`ifndef UART_RX_PARITY_EN
  assign parityErr = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic holdBits(input int bits);
    if (bits > 0) begin
      repeat (bits * N) @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting 1ns after a clock edge; queues the pulse it should produce
  task automatic applyStimulus(input uart_byte_t data, input logic stopBit, input logic flipParity,
                               input ev_t expKind, input uart_byte_t expDout);
    sb_t e;
    rx = 1'b0;
    if (expKind != EV_NONE) begin
      e.kind       = expKind;
      e.dout       = expDout;
      e.startCycle = cycle;
      sb.push_back(e);
    end
    holdBits(1);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      holdBits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ flipParity;
    holdBits(1);
`else
    if (flipParity) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
    rx = stopBit;
    holdBits(1);
  endtask

  task automatic scoreEvent(input ev_t kind);
    sb_t e;
    int  lat;
    if (sb.size() == 0) begin
      checkOutput("unexpected_pulse", 32'(kind), 32'(EV_NONE));
      return;
    end
    e   = sb.pop_front();
    lat = cycle - e.startCycle;
    checkOutput("event_kind", 32'(kind), 32'(e.kind));
    checkOutput("event_dout", 32'(rxDout), 32'(e.dout));
    checkOutput("event_latency_in_window",
                32'((lat >= LAT_NOM - LAT_TOL) && (lat <= LAT_NOM + LAT_TOL)), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rxDone || frameErr || parityErr) begin
      checkOutput("pulse_exclusive", 32'(rxDone) + 32'(frameErr) + 32'(parityErr), 32'd1);
      if (rxDone) begin
        doneCycles.push_back(cycle);
        scoreEvent(EV_DONE);
      end else if (frameErr) begin
        scoreEvent(EV_FERR);
      end else begin
        scoreEvent(EV_PERR);
      end
    end
  end

  initial begin
    uart_byte_t abortByte;

    vecs[0] = '{data: 8'hA5, stopBit: 1'b1, flipParity: 1'b0, gapBits: 2, expKind: EV_DONE, expDout: 8'hA5};
    vecs[1] = '{data: 8'h00, stopBit: 1'b1, flipParity: 1'b0, gapBits: 2, expKind: EV_DONE, expDout: 8'h00};
    vecs[2] = '{data: 8'hFF, stopBit: 1'b1, flipParity: 1'b0, gapBits: 0, expKind: EV_DONE, expDout: 8'hFF};
    vecs[3] = '{data: 8'h3C, stopBit: 1'b1, flipParity: 1'b0, gapBits: 0, expKind: EV_DONE, expDout: 8'h3C};
    vecs[4] = '{data: 8'h5A, stopBit: 1'b1, flipParity: 1'b0, gapBits: 1, expKind: EV_DONE, expDout: 8'h5A};

    rx   = 1'b1;
    rstN = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_dout", 32'(rxDout), 32'h00);
    checkOutput("reset_done", 32'(rxDone), 32'd0);
    checkOutput("reset_frame_err", 32'(frameErr), 32'd0);
    checkOutput("reset_parity_err", 32'(parityErr), 32'd0);
    checkOutput("reset_busy", 32'(rxBusy), 32'd0);
    rstN = 1'b1;
    holdBits(2);

    $display("[TB] table frames, including back-to-back 00/FF/3C");
    doneCycles.delete();
    for (int i = 0; i < NUM_VECS; i++) begin
      holdBits(vecs[i].gapBits);
      applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].flipParity, vecs[i].expKind, vecs[i].expDout);
      checkOutput("table_dout", 32'(rxDout), 32'(vecs[i].expDout));
    end
    checkOutput("table_done_count", 32'(doneCycles.size()), 32'(NUM_VECS));
    checkOutput("b2b_spacing_00_ff", 32'(doneCycles[2] - doneCycles[1]), 32'(FRAME_CYCLES));
    checkOutput("b2b_spacing_ff_3c", 32'(doneCycles[3] - doneCycles[2]), 32'(FRAME_CYCLES));

    $display("[TB] false start glitch");
    holdBits(2);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_high", 32'(rxBusy), 32'd1);
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_cleared", 32'(rxBusy), 32'd0);
    @(posedge clk);
    #1;
    holdBits(2);
    checkOutput("glitch_dout_kept", 32'(rxDout), 32'h5A);

    $display("[TB] framing error then held-low line");
    applyStimulus(8'h55, 1'b0, 1'b0, EV_FERR, 8'h5A);
    checkOutput("ferr_dout_kept", 32'(rxDout), 32'h5A);
    holdBits(20);
    checkOutput("break_busy_mid", 32'(rxBusy), 32'd1);
    holdBits(20);
    checkOutput("break_busy_end", 32'(rxBusy), 32'd1);
    checkOutput("break_dout_kept", 32'(rxDout), 32'h5A);
    rx = 1'b1;
    holdBits(2);
    checkOutput("break_released_idle", 32'(rxBusy), 32'd0);
    applyStimulus(8'h81, 1'b1, 1'b0, EV_DONE, 8'h81);
    checkOutput("after_break_dout", 32'(rxDout), 32'h81);

    $display("[TB] reset in the middle of a frame");
    holdBits(2);
    abortByte = 8'hC3;
    rx = 1'b0;
    holdBits(1);
    for (int i = 0; i < 4; i++) begin
      rx = abortByte[i];
      holdBits(1);
    end
    rx = abortByte[4];
    repeat (N / 2) @(posedge clk);
    #1;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midreset_dout", 32'(rxDout), 32'h00);
    checkOutput("midreset_busy", 32'(rxBusy), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    holdBits(FRAME_BITS);
    checkOutput("post_reset_dout", 32'(rxDout), 32'h00);
    applyStimulus(8'h7E, 1'b1, 1'b0, EV_DONE, 8'h7E);
    checkOutput("post_reset_frame_dout", 32'(rxDout), 32'h7E);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity checks");
    holdBits(2);
    applyStimulus(8'h07, 1'b1, 1'b0, EV_DONE, 8'h07);
    checkOutput("parity_good_dout", 32'(rxDout), 32'h07);
    holdBits(2);
    applyStimulus(8'h07, 1'b1, 1'b1, EV_PERR, 8'h07);
    checkOutput("parity_bad_dout", 32'(rxDout), 32'h07);
    holdBits(2);
    applyStimulus(8'h07, 1'b0, 1'b1, EV_FERR, 8'h07);
    rx = 1'b1;
    holdBits(2);
    checkOutput("parity_ferr_dout", 32'(rxDout), 32'h07);
`endif

    holdBits(2);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
